hh_neuron_scheduler: RTL
========================

# hh_neuron_scheduler

Time-multiplexes one shared Hodgkin-Huxley update engine across `N_NEURONS` virtual neurons. A free-running step timer raises a timestep tick, and each tick starts one sweep. In a sweep the scheduler presents each neuron's stored membrane voltage to the engine through a req/ack handshake, writes back the updated voltage, and collects spikes into one vector. It sits between the neuron state storage and the shared `hodgkin_huxley`-style datapath, replacing per-neuron engine instances.

## Interface
Parameters:
- `N_NEURONS`, 4: number of virtual neurons; range 2..16.
- `WIDTH`, 16: voltage word width, signed fixed point with 7 fractional bits.
- `STEP_PERIOD`, 256: clock cycles between timestep ticks; minimum 4.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: enables tick generation; the step timer counts only while high.
- `eng_req`, output, 1: engine request; held high until accepted.
- `eng_idx`, output, clog2(`N_NEURONS`): index of the neuron being updated; stable while `eng_req` is high.
- `eng_v_in`, output, `WIDTH`: stored voltage of neuron `eng_idx`; stable while `eng_req` is high.
- `eng_ack`, input, 1: engine result valid; sampled only while `eng_req` is high.
- `eng_v_out`, input, `WIDTH`: updated voltage, valid with `eng_ack`.
- `eng_spike`, input, 1: spike flag for neuron `eng_idx`, valid with `eng_ack`.
- `spike_vec`, output, `N_NEURONS`: spikes from the last completed sweep.
- `spike_valid`, output, 1: one-cycle pulse when `spike_vec` updates.
- `busy`, output, 1: high while a sweep is in progress.
- `overrun`, output, 1: sticky flag; a tick arrived while busy.
- `timeout`, output, 1: sticky flag; see Configuration.

## Operation
- FSM states:
  - IDLE: on tick, go to REQ with idx=0 and clear the working spike register.
  - REQ: `eng_req`=1. On `eng_ack`, write `eng_v_out` to `v_state[idx]` and `eng_spike` to `spike_work[idx]`. If idx=`N_NEURONS`-1, go to DONE; else increment idx and stay in REQ.
  - DONE: copy `spike_work` to `spike_vec`, pulse `spike_valid`, go to IDLE.
- `busy` = (state != IDLE).
- `v_state` is an array of `N_NEURONS` x `WIDTH` registers. Every entry resets to V_REST = -65*128 = 16'hDF80.
- The voltage passes through unmodified; the scheduler does no arithmetic on it.
- Tick arriving in REQ or DONE: the tick is dropped, `overrun` is set, and the sweep continues unaffected.
- `run` dropping mid-sweep: the current sweep completes; no new ticks are generated. The step counter holds its value (it does not clear).
- Reset asserted mid-sweep: immediate return to IDLE; all state returns to reset values; any engine transaction in flight is abandoned.
- Sticky flags clear only on reset.
- Reset values: `eng_req`=0, `eng_idx`=0, `eng_v_in`=16'hDF80 (follows `v_state[0]`), `spike_vec`=0, `spike_valid`=0, `busy`=0, `overrun`=0, `timeout`=0, step counter=0.

## Timing
- Step counter runs 0..`STEP_PERIOD`-1 while `run`=1. The tick is one cycle, at count=`STEP_PERIOD`-1.
- The first tick comes `STEP_PERIOD` cycles after `run` rises following reset.
- Tick in IDLE at cycle T: `eng_req` is high from cycle T+1.
- Same-cycle ack is legal. An ack in the first REQ cycle completes that neuron in one cycle; the next index is presented the following cycle.
- Minimum sweep: `N_NEURONS` REQ cycles + 1 DONE cycle. `spike_valid` fires at T+`N_NEURONS`+1.
- `eng_v_in` is driven combinationally from `v_state[eng_idx]`.
- `eng_ack` while `eng_req`=0 is ignored.

## Configuration
- `HH_SCHED_TIMEOUT_EN` defined:
  - A 4-bit wait counter runs in REQ and restarts on each new index.
  - If 15 cycles pass without `eng_ack`: the neuron keeps its old voltage, its spike bit reads 0, `timeout` is set, and the sweep advances to the next index.
- `HH_SCHED_TIMEOUT_EN` undefined:
  - REQ waits indefinitely.
  - `timeout` is tied to 0.

## Structure
- Package `hh_sched_pkg` holds:
  - The FSM state enum (IDLE, REQ, DONE).
  - `V_REST_Q7` = 16'hDF80.
  - Defaults for `WIDTH` and `DECIMAL_BITS`=7.
- One sub-module, `hh_step_timer`: the `run`-gated counter producing the tick.

## Test plan
- Reset, `run`=1, engine acks the same cycle with `v_out`=`v_in`+1 and spike only on idx 2 -> after the first sweep, `spike_vec`=4'b0100, `spike_valid` pulses once at tick+5, all `v_state` read 16'hDF81.
- Engine acks 3 cycles after each request -> `eng_idx` and `eng_v_in` stable throughout each wait; sweep length 4*4+1 = 17 cycles.
- `STEP_PERIOD`=8, engine acks 3 cycles after each request -> second tick lands mid-sweep, `overrun`=1 and stays 1; the sweep still completes with correct writebacks.
- Assert `reset_n` low in REQ with idx=2 -> `eng_req`=0 and `busy`=0 immediately; every voltage reads 16'hDF80 afterwards.
- `HH_SCHED_TIMEOUT_EN` defined, engine never acks idx 1 -> after 15 cycles `timeout`=1, `v_state[1]` unchanged, bit 1 of `spike_vec`=0, idx 2 presented next cycle.
- Drop `run` mid-sweep -> sweep finishes with `spike_valid` pulse; no further `eng_req` for 3*`STEP_PERIOD` cycles.

Source files
------------

// File: rtl/hh_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hh_sched_pkg                                               |
// | Description : Shared types and constants for the HH neuron scheduler.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package hh_sched_pkg;

    localparam int          WIDTH_DEFAULT = 16;
    localparam int          DECIMAL_BITS  = 7;
    // Resting potential -65 mV in Q7.
    localparam logic [15:0] V_REST_Q7     = 16'hDF80;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/hh_step_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hh_step_timer                                              |
// | Description : run-gated free-running counter, one-cycle timestep tick.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hh_step_timer #(
    parameter int STEP_PERIOD = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int                 c_CNT_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(STEP_PERIOD - 1);

    logic [c_CNT_W-1:0] r_count;

    // Counter holds (does not clear) while run is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + c_CNT_W'(1);
        end
    end

    assign tick = run && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/hh_neuron_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hh_neuron_scheduler                                        |
// | Description : Sweeps N virtual neurons through one shared HH engine per  |
// |               timestep. Optional per-neuron ack timeout: define          |
// |               HH_SCHED_TIMEOUT_EN.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hh_neuron_scheduler
    import hh_sched_pkg::*;
#(
    parameter int N_NEURONS   = 4,
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int STEP_PERIOD = 256
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         run,
    output logic                         eng_req,
    output logic [$clog2(N_NEURONS)-1:0] eng_idx,
    output logic [WIDTH-1:0]             eng_v_in,
    input  logic                         eng_ack,
    input  logic [WIDTH-1:0]             eng_v_out,
    input  logic                         eng_spike,
    output logic [N_NEURONS-1:0]         spike_vec,
    output logic                         spike_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic                         timeout
);

    localparam int              c_IW       = $clog2(N_NEURONS);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(N_NEURONS - 1);
    localparam logic [WIDTH-1:0] c_V_REST  = WIDTH'($signed(V_REST_Q7));

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [c_IW-1:0]      r_idx;
    logic [WIDTH-1:0]     r_v_state [N_NEURONS];
    logic [N_NEURONS-1:0] r_spike_work;
    logic [N_NEURONS-1:0] w_spike_work_nxt;
    logic [N_NEURONS-1:0] r_spike_vec;
    logic                 r_spike_valid;
    logic                 r_overrun;
    logic                 w_tick;
    logic                 w_start;
    logic                 w_advance;
    logic                 w_timeout_hit;
    logic                 w_wait_expired;
    logic                 w_last;
    logic                 w_wr_en;

    hh_step_timer #(
        .STEP_PERIOD (STEP_PERIOD)
    ) u_step_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .tick    (w_tick)
    );

    assign w_last  = (r_idx == c_LAST_IDX);
    assign w_wr_en = (r_state == S_REQ) && eng_ack;

    always_comb begin
        w_state_nxt      = r_state;
        w_start          = 1'b0;
        w_advance        = 1'b0;
        w_timeout_hit    = 1'b0;
        w_spike_work_nxt = r_spike_work;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = S_REQ;
                    w_start     = 1'b1;
                end
            end
            S_REQ: begin
                if (eng_ack) begin
                    w_advance = 1'b1;
                end else if (w_wait_expired) begin
                    w_advance     = 1'b1;
                    w_timeout_hit = 1'b1;
                end
                // A timed-out neuron records no spike.
                if (w_advance) begin
                    w_spike_work_nxt[r_idx] = eng_ack & eng_spike;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_spike_work  <= '0;
            r_spike_vec   <= '0;
            r_spike_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_spike_valid <= w_advance && w_last;
            if (w_start) begin
                r_idx        <= '0;
                r_spike_work <= '0;
            end else if (w_advance) begin
                r_spike_work <= w_spike_work_nxt;
                if (!w_last) begin
                    r_idx <= r_idx + c_IW'(1);
                end
            end
            // spike_vec is published together with the DONE-cycle valid pulse.
            if (w_advance && w_last) begin
                r_spike_vec <= w_spike_work_nxt;
            end
            if (w_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v_state[i] <= c_V_REST;
            end
        end else if (w_wr_en) begin
            r_v_state[r_idx] <= eng_v_out;
        end
    end

`ifdef HH_SCHED_TIMEOUT_EN
    localparam logic [3:0] c_WAIT_LAST = 4'd14;

    logic [3:0] r_wait;
    logic       r_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state != S_REQ) || w_advance) begin
                r_wait <= '0;
            end else begin
                r_wait <= r_wait + 4'd1;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_wait_expired = (r_state == S_REQ) && (r_wait == c_WAIT_LAST);
    assign timeout        = r_timeout;
`else
    assign w_wait_expired = 1'b0;
    assign timeout        = 1'b0;
`endif

    assign eng_req     = (r_state == S_REQ);
    assign eng_idx     = r_idx;
    assign eng_v_in    = r_v_state[r_idx];
    assign busy        = (r_state != S_IDLE);
    assign spike_vec   = r_spike_vec;
    assign spike_valid = r_spike_valid;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire
